uart_1to20_router: RTL and testbench
====================================

# uart_1to20_router

Frame router that receives command frames from a host UART and re-transmits each frame's payload on one of 20 downstream UART channels. It sits between the host processor's UART and 20 peripheral serial links. Each accepted or rejected frame is answered with a one-byte ACK/NAK on the host UART. The SPI slave port is reserved in this revision.

## Interface
- CLKS_PER_BIT, 69: clocks per UART bit (8 MHz / 115200 baud), used by all serializers.
- MAX_LEN, 32: maximum payload bytes per frame.
- clk  in  1  8 MHz system clock; everything is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- spi_mosi  in  1  reserved, ignored.
- spi_cs_n  in  1  reserved, ignored.
- spi_clk  in  1  reserved, ignored.
- spi_miso  out  1  reserved, held 0.
- uart_tx_to_fpga  in  1  host-to-router serial data, 8N1.
- uart_rx_from_fpga  out  1  router-to-host ACK/NAK serial data, 8N1, idle high.
- uart_rx  in  20  channel receive lines; reserved and ignored in this revision.
- uart_tx  out  20  channel transmit lines, 8N1, idle high.

## Operation
- **Host receiver**
  - uart_tx_to_fpga passes through a 2-FF synchronizer.
  - A start bit is detected on a falling edge and confirmed at mid-bit. 8 data bits are sampled LSB-first at mid-bit.
  - The stop bit must be 1. If it is 0, the byte is dropped and the parser returns to IDLE without sending a NAK.
- **Frame format:** 0x24 0x43 0x54 0x46 ("$CTF"), LEN, CHAN, LEN data bytes, CRC0, CRC1, 0xFE.
- **Parser states:** IDLE, H1, H2, H3, LEN, CHAN, DATA, CRC0, CRC1, END, FWD, RESP.
  - Header mismatch in IDLE..H3: go to IDLE. If the mismatching byte is 0x24, go to H1 instead.
  - LEN must be in 1..MAX_LEN; otherwise the frame is an error.
  - CHAN must be in 0x11..0x24; it selects channel k = CHAN − 0x11. Any other value is an error.
  - Data bytes are stored in a MAX_LEN-byte buffer, with a write counter that wraps at LEN.
  - CRC0 and CRC1 are received and discarded; no CRC check is made.
  - END byte ≠ 0xFE: error.
- **Error path:** LEN/CHAN errors are flagged but the frame is not tracked further. The parser goes to RESP and sends NAK 0x55. Bytes still arriving while in RESP are discarded.
- **FWD state:** the shared TX serializer sends buffer bytes 0..LEN−1 back-to-back on uart_tx[k]. All other uart_tx bits stay high. After the last stop bit, go to RESP.
- **RESP state:** send ACK 0xAA (success) or NAK 0x55 (error) on uart_rx_from_fpga, then return to IDLE.
- The host receiver stays active in FWD and RESP, but received bytes are discarded until the parser is in IDLE.

## Timing
- Bit period is CLKS_PER_BIT clocks; a frame is 10 bits (start, 8 data LSB-first, stop).
- Reset values: uart_tx = 20'hFFFFF, uart_rx_from_fpga = 1, spi_miso = 0, parser in IDLE, counters 0.
- Reset asserted mid-frame or mid-transmission aborts immediately; all lines are high on the cycle after rst.
- The first start bit on uart_tx[k] begins 1–2 clocks after the stop-bit sample of the 0xFE byte.
- Consecutive payload bytes have no idle gap: each stop bit is followed directly by the next start bit.
- The ACK/NAK start bit begins within 2 clocks after the last payload stop bit ends (or after the error is detected).
- Receiver oversampling uses no fractional baud compensation: ±2% tolerance at the default divisor.

## Structure
- Package uart_router_pkg:
  - constants: header bytes, END_BYTE = 0xFE, ACK = 0xAA, NAK = 0x55, CHAN_BASE = 0x11, NUM_CH = 20;
  - the parser state enum.
- Sub-module uart_byte_tx (shared serializer, one-hot output steer in top), used twice: once for channel forwarding, once for host responses.
- The receiver is inline or a uart_byte_rx sub-module.

## Test plan
- Frame 24 43 54 46 04 11 35 47 65 78 39 47 FE → uart_tx[0] emits 35 47 65 78; then host line gets 0xAA; other channels stay high.
- Frame 24 43 54 46 06 12 35 47 65 78 65 78 39 47 FE → uart_tx[1] emits the 6 bytes in order; then 0xAA.
- Same as the first frame but the last byte is 0xFD → no channel activity; host gets 0x55.
- CHAN = 0x30 (and LEN = 0x00 in a separate frame) → host gets 0x55; uart_tx stays 20'hFFFFF.
- Garbage 24 24 43 54 46 … valid rest, CHAN 0x24 → second 0x24 restarts the header; uart_tx[19] forwards the payload; then 0xAA.
- rst asserted in the middle of FWD → uart_tx returns high next clock; a subsequent valid frame is routed correctly.

Source files
------------

// File: rtl/uart_router_pkg.sv
// Shared constants, parser state encoding and small helpers for the 1-to-20 UART frame router.
package uart_router_pkg;

    localparam logic [7:0] HDR0      = 8'h24;
    localparam logic [7:0] HDR1      = 8'h43;
    localparam logic [7:0] HDR2      = 8'h54;
    localparam logic [7:0] HDR3      = 8'h46;
    localparam logic [7:0] END_BYTE  = 8'hFE;
    localparam logic [7:0] ACK       = 8'hAA;
    localparam logic [7:0] NAK       = 8'h55;
    localparam logic [7:0] CHAN_BASE = 8'h11;
    localparam logic [7:0] CHAN_LAST = 8'h24;
    localparam int         NUM_CH    = 20;

    typedef enum logic [3:0] {
        ST_IDLE, ST_H1, ST_H2, ST_H3, ST_LEN, ST_CHAN,
        ST_DATA, ST_CRC0, ST_CRC1, ST_END, ST_FWD, ST_RESP
    } parser_state_t;

    // A mismatching 0x24 is itself a valid first header byte, so it restarts the header.
    function automatic parser_state_t hdr_step(input logic [7:0] b, input logic [7:0] want,
                                               input parser_state_t nxt);
        if (b == want) begin
            return nxt;
        end else if (b == HDR0) begin
            return ST_H1;
        end else begin
            return ST_IDLE;
        end
    endfunction

    function automatic logic [NUM_CH-1:0] chan_onehot(input logic [4:0] k);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << k;
    endfunction

endpackage

// File: rtl/uart_1to20_router_if.sv
// Pin bundle of the router: host UART pair, 20 channel UART pairs and the reserved SPI slave.
interface uart_1to20_router_if;
    import uart_router_pkg::*;

    logic              spi_mosi;
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_miso;
    logic              uart_tx_to_fpga;
    logic              uart_rx_from_fpga;
    logic [NUM_CH-1:0] uart_rx;
    logic [NUM_CH-1:0] uart_tx;

    modport master (
        output spi_mosi, spi_cs_n, spi_clk, uart_tx_to_fpga, uart_rx,
        input  spi_miso, uart_rx_from_fpga, uart_tx
    );

    modport slave (
        input  spi_mosi, spi_cs_n, spi_clk, uart_tx_to_fpga, uart_rx,
        output spi_miso, uart_rx_from_fpga, uart_tx
    );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer; a new byte offered on the last stop-bit clock follows with no idle gap.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 69
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       ready
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [9:0]       shift_r;
    logic             busy_r;
    logic             tx_r;
    logic             bit_end_s;
    logic             frame_end_s;

    assign bit_end_s   = (clk_cnt_r == CNT_LAST);
    assign frame_end_s = busy_r && bit_end_s && (bit_cnt_r == 4'd9);
    assign ready       = !busy_r || frame_end_s;
    assign busy        = busy_r;
    assign tx          = tx_r;

    // Bit timer and shift register; the line is driven straight from tx_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= 4'd0;
            shift_r   <= 10'h3FF;
            busy_r    <= 1'b0;
            tx_r      <= 1'b1;
        end else if (start && ready) begin
            shift_r   <= {1'b1, data, 1'b0};
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= 4'd0;
        end else if (frame_end_s) begin
            busy_r    <= 1'b0;
            tx_r      <= 1'b1;
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= 4'd0;
        end else if (busy_r) begin
            if (bit_end_s) begin
                clk_cnt_r <= {CNT_W{1'b0}};
                bit_cnt_r <= bit_cnt_r + 4'd1;
                shift_r   <= {1'b1, shift_r[9:1]};
                tx_r      <= shift_r[1];
            end else begin
                clk_cnt_r <= clk_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_1to20_router.sv
// Host frame receiver/parser that forwards each frame payload to one of 20 channel UARTs
// and answers the host with ACK/NAK.
module uart_1to20_router
    import uart_router_pkg::*;
#(
    parameter int CLKS_PER_BIT = 69,
    parameter int MAX_LEN      = 32
) (
    input logic                clk,
    input logic                rst,
    uart_1to20_router_if.slave bus
);
    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RX_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int               IDX_W   = $clog2(MAX_LEN);
    localparam int               LEN_W   = IDX_W + 1;
    localparam logic [7:0]       LEN_MAX = 8'(MAX_LEN);

    // host receiver
    logic             rx_meta_r, rx_sync_r, rx_prev_r, rx_busy_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [3:0]       rx_bit_r;
    logic [7:0]       rx_shift_r, rx_byte_r;
    logic             rx_valid_r, rx_ferr_r;

    // parser
    parser_state_t    state_r, state_n;
    logic [LEN_W-1:0] len_r, len_n, data_cnt_r, data_cnt_n, fwd_idx_r, fwd_idx_n;
    logic [IDX_W-1:0] wr_idx_r, wr_idx_n;
    logic [4:0]       chan_r, chan_n;
    logic             err_r, err_n, resp_started_r, resp_started_n;
    logic             wr_en_s, fwd_start_s, resp_start_s, parsing_s;
    logic [7:0]       buf_r [MAX_LEN];

    // serializers and line drivers
    logic [7:0]        fwd_data_s, resp_data_s;
    logic              fwd_line_s, fwd_busy_s, fwd_ready_s;
    logic              resp_line_s, resp_busy_s, unused_resp_ready_s;
    logic [NUM_CH-1:0] uart_tx_r;
    logic              unused_inputs_s;

    // Host receiver: 2-FF synchronizer, start confirmed at mid-bit, data sampled LSB-first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            rx_busy_r  <= 1'b0;
            rx_cnt_r   <= {CNT_W{1'b0}};
            rx_bit_r   <= 4'd0;
            rx_shift_r <= 8'h00;
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_meta_r  <= bus.uart_tx_to_fpga;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            rx_valid_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            if (!rx_busy_r) begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_busy_r <= 1'b1;
                    rx_cnt_r  <= {CNT_W{1'b0}};
                    rx_bit_r  <= 4'd0;
                end
            end else if (rx_bit_r == 4'd0) begin
                if (rx_cnt_r == RX_HALF) begin
                    rx_cnt_r <= {CNT_W{1'b0}};
                    if (rx_sync_r) begin
                        rx_busy_r <= 1'b0;
                    end else begin
                        rx_bit_r <= 4'd1;
                    end
                end else begin
                    rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                end
            end else if (rx_cnt_r == RX_LAST) begin
                rx_cnt_r <= {CNT_W{1'b0}};
                if (rx_bit_r == 4'd9) begin
                    rx_busy_r <= 1'b0;
                    rx_bit_r  <= 4'd0;
                    if (rx_sync_r) begin
                        rx_valid_r <= 1'b1;
                        rx_byte_r  <= rx_shift_r;
                    end else begin
                        rx_ferr_r <= 1'b1;
                    end
                end else begin
                    rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_r   <= rx_bit_r + 4'd1;
                end
            end else begin
                rx_cnt_r <= rx_cnt_r + CNT_W'(1);
            end
        end
    end

    assign parsing_s = (state_r != ST_FWD) && (state_r != ST_RESP);

    // Parser next-state and control; received bytes are ignored in FWD and RESP.
    always_comb begin
        state_n        = state_r;
        len_n          = len_r;
        chan_n         = chan_r;
        wr_idx_n       = wr_idx_r;
        data_cnt_n     = data_cnt_r;
        fwd_idx_n      = fwd_idx_r;
        err_n          = err_r;
        resp_started_n = resp_started_r;
        wr_en_s        = 1'b0;
        fwd_start_s    = 1'b0;
        resp_start_s   = 1'b0;
        if (rx_ferr_r && parsing_s) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_H1, ST_H2, ST_H3: begin
                    if (rx_valid_r) begin
                        case (state_r)
                            ST_IDLE: state_n = hdr_step(rx_byte_r, HDR0, ST_H1);
                            ST_H1:   state_n = hdr_step(rx_byte_r, HDR1, ST_H2);
                            ST_H2:   state_n = hdr_step(rx_byte_r, HDR2, ST_H3);
                            default: state_n = hdr_step(rx_byte_r, HDR3, ST_LEN);
                        endcase
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_LEN: begin
                    if (!rx_valid_r) begin
                        state_n = state_r;
                    end else if ((rx_byte_r == 8'd0) || (rx_byte_r > LEN_MAX)) begin
                        err_n   = 1'b1;
                        state_n = ST_RESP;
                    end else begin
                        len_n   = rx_byte_r[LEN_W-1:0];
                        state_n = ST_CHAN;
                    end
                end
                ST_CHAN: begin
                    if (!rx_valid_r) begin
                        state_n = state_r;
                    end else if ((rx_byte_r < CHAN_BASE) || (rx_byte_r > CHAN_LAST)) begin
                        err_n   = 1'b1;
                        state_n = ST_RESP;
                    end else begin
                        chan_n     = 5'(rx_byte_r - CHAN_BASE);
                        wr_idx_n   = {IDX_W{1'b0}};
                        data_cnt_n = {LEN_W{1'b0}};
                        fwd_idx_n  = {LEN_W{1'b0}};
                        state_n    = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_valid_r) begin
                        wr_en_s    = 1'b1;
                        data_cnt_n = data_cnt_r + LEN_W'(1);
                        if ((LEN_W'(wr_idx_r) + LEN_W'(1)) == len_r) begin
                            wr_idx_n = {IDX_W{1'b0}};
                        end else begin
                            wr_idx_n = wr_idx_r + IDX_W'(1);
                        end
                        if ((data_cnt_r + LEN_W'(1)) == len_r) begin
                            state_n = ST_CRC0;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_CRC0: state_n = rx_valid_r ? ST_CRC1 : ST_CRC0;
                ST_CRC1: state_n = rx_valid_r ? ST_END : ST_CRC1;
                ST_END: begin
                    if (!rx_valid_r) begin
                        state_n = state_r;
                    end else if (rx_byte_r == END_BYTE) begin
                        fwd_start_s = 1'b1;
                        fwd_idx_n   = LEN_W'(1);
                        state_n     = ST_FWD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_RESP;
                    end
                end
                ST_FWD: begin
                    if (fwd_idx_r != len_r) begin
                        if (fwd_ready_s) begin
                            fwd_start_s = 1'b1;
                            fwd_idx_n   = fwd_idx_r + LEN_W'(1);
                        end else begin
                            fwd_start_s = 1'b0;
                        end
                    end else if (!fwd_busy_s) begin
                        state_n = ST_RESP;
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_RESP: begin
                    if (!resp_started_r) begin
                        resp_start_s   = 1'b1;
                        resp_started_n = 1'b1;
                    end else if (!resp_busy_s) begin
                        resp_started_n = 1'b0;
                        err_n          = 1'b0;
                        state_n        = ST_IDLE;
                    end else begin
                        state_n = state_r;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Parser state and frame bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            len_r          <= {LEN_W{1'b0}};
            chan_r         <= 5'd0;
            wr_idx_r       <= {IDX_W{1'b0}};
            data_cnt_r     <= {LEN_W{1'b0}};
            fwd_idx_r      <= {LEN_W{1'b0}};
            err_r          <= 1'b0;
            resp_started_r <= 1'b0;
        end else begin
            state_r        <= state_n;
            len_r          <= len_n;
            chan_r         <= chan_n;
            wr_idx_r       <= wr_idx_n;
            data_cnt_r     <= data_cnt_n;
            fwd_idx_r      <= fwd_idx_n;
            err_r          <= err_n;
            resp_started_r <= resp_started_n;
        end
    end

    // Payload buffer; contents are only meaningful once DATA has filled them.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[wr_idx_r] <= rx_byte_r;
        end
    end

    assign fwd_data_s  = buf_r[fwd_idx_r[IDX_W-1:0]];
    assign resp_data_s = err_r ? NAK : ACK;

    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_fwd_tx (
        .clk   (clk),
        .rst   (rst),
        .start (fwd_start_s),
        .data  (fwd_data_s),
        .tx    (fwd_line_s),
        .busy  (fwd_busy_s),
        .ready (fwd_ready_s)
    );

    uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_resp_tx (
        .clk   (clk),
        .rst   (rst),
        .start (resp_start_s),
        .data  (resp_data_s),
        .tx    (resp_line_s),
        .busy  (resp_busy_s),
        .ready (unused_resp_ready_s)
    );

    // Steer the shared forwarding serializer onto the selected channel; all others idle high.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_r <= {NUM_CH{1'b1}};
        end else begin
            uart_tx_r <= fwd_line_s ? {NUM_CH{1'b1}} : ~chan_onehot(chan_r);
        end
    end

    assign bus.uart_tx           = uart_tx_r;
    assign bus.uart_rx_from_fpga = resp_line_s;
    assign bus.spi_miso          = 1'b0;
    assign unused_inputs_s       = ^{bus.spi_mosi, bus.spi_cs_n, bus.spi_clk, bus.uart_rx};

endmodule

// File: tb/tb_uart_1to20_router.sv
// Directed and randomized frame stimulus for uart_1to20_router, checked against a frame-level model.
module tb_uart_1to20_router;
    import uart_router_pkg::*;

    localparam int CPB   = 10;
    localparam int MAXL  = 32;
    localparam int WAITC = (MAXL + 12) * 10 * CPB * 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_1to20_router_if ifc();

    uart_1to20_router #(.CLKS_PER_BIT(CPB), .MAX_LEN(MAXL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  frame_q [$];
    logic [12:0] fwd_log [$];
    logic [7:0]  resp_log [$];
    logic [12:0] exp_fwd [$];
    logic [7:0]  exp_resp [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input int ch);
        if (ch >= NUM_CH) return ifc.uart_rx_from_fpga;
        else return ifc.uart_tx[ch];
    endfunction

    // Decode one 8N1 byte whose start edge has just been seen on line ch.
    task automatic rx_line_byte(input int ch, output logic [7:0] d, output logic ok);
        repeat (CPB / 2) @(negedge clk);
        ok = (line_of(ch) == 1'b0);
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            d[b] = line_of(ch);
        end
        repeat (CPB) @(negedge clk);
        ok = ok && (line_of(ch) == 1'b1);
    endtask

    for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
        initial begin : mon
            logic [7:0] d;
            logic       ok;
            forever begin
                @(negedge ifc.uart_tx[g]);
                rx_line_byte(g, d, ok);
                fwd_log.push_back({ok ? 5'(g) : 5'd31, d});
            end
        end
    end

    initial begin : host_mon
        logic [7:0] d;
        logic       ok;
        forever begin
            @(negedge ifc.uart_rx_from_fpga);
            rx_line_byte(NUM_CH, d, ok);
            resp_log.push_back(ok ? d : 8'h00);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ifc.uart_tx_to_fpga = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Frame-level reference: locate "$CTF", apply the LEN/CHAN/END rules, list what must appear.
    task automatic model();
        int         h;
        int         p;
        int         len;
        logic [7:0] ch;
        exp_fwd.delete();
        exp_resp.delete();
        h = -1;
        for (int i = 0; i + 3 < frame_q.size(); i++) begin
            if (h < 0 && frame_q[i] == 8'h24 && frame_q[i+1] == 8'h43 &&
                frame_q[i+2] == 8'h54 && frame_q[i+3] == 8'h46) h = i;
        end
        if (h < 0) return;
        p   = h + 4;
        len = int'(frame_q[p]);
        if (len < 1 || len > MAXL) begin exp_resp.push_back(8'h55); return; end
        ch = frame_q[p+1];
        if (ch < 8'h11 || ch > 8'h24) begin exp_resp.push_back(8'h55); return; end
        if (frame_q[p + 2 + len + 2] != 8'hFE) begin exp_resp.push_back(8'h55); return; end
        for (int j = 0; j < len; j++) exp_fwd.push_back({5'(ch - 8'h11), frame_q[p+2+j]});
        exp_resp.push_back(8'hAA);
    endtask

    task automatic make_frame(input int len, input logic [7:0] ch, input logic [7:0] end_b);
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46};
        frame_q.push_back(8'(len));
        frame_q.push_back(ch);
        for (int j = 0; j < len; j++) frame_q.push_back(8'($urandom));
        frame_q.push_back(8'($urandom));
        frame_q.push_back(8'($urandom));
        frame_q.push_back(end_b);
    endtask

    task automatic run_frame(input string tag);
        int n;
        model();
        fwd_log.delete();
        resp_log.delete();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        n = 0;
        while (n < WAITC && resp_log.size() == 0) begin
            @(negedge clk);
            n++;
        end
        repeat (30 * CPB) @(negedge clk);
        check({tag, " resp_count"}, 32'(resp_log.size()), 32'(exp_resp.size()));
        for (int i = 0; i < resp_log.size() && i < exp_resp.size(); i++)
            check({tag, " resp_byte"}, 32'(resp_log[i]), 32'(exp_resp[i]));
        check({tag, " fwd_count"}, 32'(fwd_log.size()), 32'(exp_fwd.size()));
        for (int i = 0; i < fwd_log.size() && i < exp_fwd.size(); i++)
            check({tag, " fwd_chan_byte"}, 32'(fwd_log[i]), 32'(exp_fwd[i]));
        check({tag, " idle_uart_tx"}, 32'(ifc.uart_tx), 32'h000FFFFF);
    endtask

    initial begin : stim
        int   n;
        logic started;
        rst                 = 1'b1;
        ifc.uart_tx_to_fpga = 1'b1;
        ifc.uart_rx         = 20'hFFFFF;
        ifc.spi_mosi        = 1'b0;
        ifc.spi_cs_n        = 1'b1;
        ifc.spi_clk         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset uart_tx", 32'(ifc.uart_tx), 32'h000FFFFF);
        check("reset host_line", 32'(ifc.uart_rx_from_fpga), 32'd1);
        check("reset spi_miso", 32'(ifc.spi_miso), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h11, 8'h35, 8'h47, 8'h65, 8'h78,
                    8'h39, 8'h47, 8'hFE};
        run_frame("ch0_len4");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h06, 8'h12, 8'h35, 8'h47, 8'h65, 8'h78,
                    8'h65, 8'h78, 8'h39, 8'h47, 8'hFE};
        run_frame("ch1_len6");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h11, 8'h35, 8'h47, 8'h65, 8'h78,
                    8'h39, 8'h47, 8'hFD};
        run_frame("bad_end");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h30};
        run_frame("chan_30");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h10};
        run_frame("chan_10");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h25};
        run_frame("chan_25");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h00};
        run_frame("len_0");
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h21};
        run_frame("len_33");
        frame_q = '{8'h24, 8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h24, 8'h35, 8'h47, 8'h65,
                    8'h78, 8'h39, 8'h47, 8'hFE};
        run_frame("restart_ch19");
        make_frame(MAXL, 8'h11, 8'hFE);
        run_frame("len_max");
        make_frame(1, 8'h24, 8'hFE);
        run_frame("len_1");

        for (int r = 0; r < 6; r++) begin
            make_frame(int'($urandom_range(16, 1)), 8'($urandom_range(32'h24, 32'h11)), 8'hFE);
            run_frame("random");
        end

        make_frame(8, 8'h15, 8'hFE);
        foreach (frame_q[i]) send_byte(frame_q[i]);
        started = 1'b0;
        n = 0;
        while (n < WAITC && !started) begin
            @(negedge clk);
            started = (ifc.uart_tx != 20'hFFFFF);
            n++;
        end
        check("midfwd started", 32'(started), 32'd1);
        repeat (25 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midfwd reset uart_tx", 32'(ifc.uart_tx), 32'h000FFFFF);
        check("midfwd reset host_line", 32'(ifc.uart_rx_from_fpga), 32'd1);
        rst = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        frame_q = '{8'h24, 8'h43, 8'h54, 8'h46, 8'h04, 8'h11, 8'h35, 8'h47, 8'h65, 8'h78,
                    8'h39, 8'h47, 8'hFE};
        run_frame("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
